// File: rtl/descriptor_fetch_master.sv
// Avalon-MM read master that walks a linked list of 4-word descriptors and
// hands each hardware-owned descriptor to a downstream engine over valid/ready.
module descriptor_fetch_master #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned MAX_DESC = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    output logic              desc_valid,
    input  logic              desc_ready,
    output logic [31:0]       desc_next,
    output logic [31:0]       desc_buf_addr,
    output logic [15:0]       desc_length,
    output logic [31:0]       desc_ctrl,
    output logic [15:0]       desc_count
);

    localparam logic [15:0] MaxDesc = 16'(MAX_DESC);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitData,
        StCheck,
        StPresent,
        StDone,
        StError
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        req_idx_q, req_idx_d;
    logic [1:0]        beat_idx_q, beat_idx_d;
    logic [31:0]       w0_q, w0_d;
    logic [31:0]       w1_q, w1_d;
    logic [15:0]       w2_q, w2_d;
    logic [31:0]       w3_q, w3_d;
    logic              stop_q, stop_d;
    logic              bad_start_q, bad_start_d;
    logic [31:0]       next_q, next_d;
    logic [31:0]       buf_q, buf_d;
    logic [15:0]       len_q, len_d;
    logic [31:0]       ctrl_q, ctrl_d;
    logic [15:0]       count_q, count_d;

    logic        capture;
    logic        last_beat;
    logic        req_accept;
    logic [15:0] count_inc;

    assign busy       = (state_q == StIssue) || (state_q == StWaitData) ||
                        (state_q == StCheck) || (state_q == StPresent);
    assign done       = (state_q == StDone);
    assign error      = (state_q == StError) || bad_start_q;
    assign m_read     = (state_q == StIssue);
    assign m_address  = m_read ? base_q + ADDR_W'({req_idx_q, 2'b00}) : '0;
    assign desc_valid = (state_q == StPresent);

    assign desc_next     = next_q;
    assign desc_buf_addr = buf_q;
    assign desc_length   = len_q;
    assign desc_ctrl     = ctrl_q;
    assign desc_count    = count_q;

    // Beats only count while a descriptor read is in flight; stray strobes are dropped.
    assign capture    = ((state_q == StIssue) || (state_q == StWaitData)) && m_readdatavalid;
    assign last_beat  = capture && (beat_idx_q == 2'd3);
    assign req_accept = (state_q == StIssue) && !m_waitrequest;
    assign count_inc  = count_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        req_idx_d   = req_idx_q;
        beat_idx_d  = beat_idx_q;
        w0_d        = w0_q;
        w1_d        = w1_q;
        w2_d        = w2_q;
        w3_d        = w3_q;
        stop_d      = stop_q;
        bad_start_d = 1'b0;
        next_d      = next_q;
        buf_d       = buf_q;
        len_d       = len_q;
        ctrl_d      = ctrl_q;
        count_d     = count_q;

        if (capture) begin
            beat_idx_d = beat_idx_q + 2'd1;
            case (beat_idx_q)
                2'd0:    w0_d = m_readdata;
                2'd1:    w1_d = m_readdata;
                2'd2:    w2_d = m_readdata[15:0];
                default: w3_d = m_readdata;
            endcase
        end

        if (busy && stop) begin
            stop_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (start_addr[1:0] != 2'b00) begin
                        bad_start_d = 1'b1;
                    end else begin
                        base_d     = start_addr;
                        count_d    = '0;
                        stop_d     = 1'b0;
                        req_idx_d  = '0;
                        beat_idx_d = '0;
                        state_d    = StIssue;
                    end
                end
            end
            StIssue: begin
                if (req_accept) begin
                    req_idx_d = req_idx_q + 2'd1;
                    if (req_idx_q == 2'd3) begin
                        state_d = last_beat ? StCheck : StWaitData;
                    end
                end
            end
            StWaitData: begin
                if (last_beat) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                // Software-owned descriptor terminates the chain without being presented.
                if (!w3_q[31]) begin
                    state_d = StDone;
                end else begin
                    next_d  = w0_q;
                    buf_d   = w1_q;
                    len_d   = w2_q;
                    ctrl_d  = w3_q;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                if (desc_ready) begin
                    count_d = count_inc;
                    if (stop_q || stop) begin
                        state_d = StDone;
                    end else if (next_q == 32'd0) begin
                        state_d = StDone;
                    end else if (next_q[1:0] != 2'b00) begin
                        state_d = StError;
                    end else if (count_inc == MaxDesc) begin
                        state_d = StError;
                    end else begin
                        base_d     = next_q[ADDR_W-1:0];
                        req_idx_d  = '0;
                        beat_idx_d = '0;
                        state_d    = StIssue;
                    end
                end
            end
            StDone:  state_d = StIdle;
            StError: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            base_q      <= '0;
            req_idx_q   <= '0;
            beat_idx_q  <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            w2_q        <= '0;
            w3_q        <= '0;
            stop_q      <= 1'b0;
            bad_start_q <= 1'b0;
            next_q      <= '0;
            buf_q       <= '0;
            len_q       <= '0;
            ctrl_q      <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            req_idx_q   <= req_idx_d;
            beat_idx_q  <= beat_idx_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            w2_q        <= w2_d;
            w3_q        <= w3_d;
            stop_q      <= stop_d;
            bad_start_q <= bad_start_d;
            next_q      <= next_d;
            buf_q       <= buf_d;
            len_q       <= len_d;
            ctrl_q      <= ctrl_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: doc/descriptor_fetch_master.md
Name: descriptor_fetch_master

Overview:
Avalon-MM read master that walks a linked list of 4-word descriptors held in the on-chip descriptor memory. It presents each valid descriptor to a downstream DMA/packet engine over a valid/ready handshake. It follows each descriptor's next pointer until the chain ends, a stop is requested, or an error is detected. It is the reading end of the descriptor memory's Avalon slave port; software writes the descriptor chain into that memory.

Parameters:
ADDR_W, 12, byte-address width of m_address; 1024 words x 4 bytes.
MAX_DESC, 256, runaway guard: maximum descriptors presented per start before an error is flagged.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle pulse; begin a walk at start_addr
start_addr  in  ADDR_W  byte address of the first descriptor
stop  in  1  pulse; end the walk at the next descriptor boundary
busy  out  1  high from an accepted start until done/error
done  out  1  one-cycle pulse at normal end of walk
error  out  1  one-cycle pulse: misaligned pointer or MAX_DESC exceeded
m_address  out  ADDR_W  Avalon byte address, word aligned
m_read  out  1  Avalon read request
m_waitrequest  in  1  Avalon wait; request held while high
m_readdata  in  32  Avalon read data
m_readdatavalid  in  1  Avalon read data strobe
desc_valid  out  1  descriptor available
desc_ready  in  1  consumer accepts descriptor
desc_next  out  32  word0: next descriptor byte address; 0 = end of chain
desc_buf_addr  out  32  word1: buffer address
desc_length  out  16  word2[15:0]: buffer length in bytes
desc_ctrl  out  32  word3: bit31 OWNED (1 = hardware-owned), bit30 EOP, others pass through
desc_count  out  16  descriptors accepted since the last start

Behaviour:
- Reset values: busy=0, done=0, error=0, m_read=0, m_address=0, desc_valid=0, all desc_* fields=0, desc_count=0, state=IDLE. Reset mid-walk discards everything, including outstanding reads.
- IDLE:
  - start with start_addr[1:0]!=0 -> error pulse next cycle; remain IDLE.
  - start with start_addr[1:0]==0 -> base<=start_addr, desc_count<=0, stop latch cleared, busy=1, go to ISSUE.
  - start while busy is ignored.
- ISSUE:
  - m_read=1, m_address=base+4*i for i=0..3.
  - Outputs are held stable while m_waitrequest=1; i advances only when m_waitrequest=0.
  - Address arithmetic is modulo 2^ADDR_W (wraps).
  - After the 4th accepted request, m_read=0 and go to WAIT_DATA.
- Data capture runs in ISSUE and WAIT_DATA:
  - A beat counter j (0..3) stores m_readdata into word j on each m_readdatavalid.
  - Data may arrive one cycle after acceptance, so a beat can land while still in ISSUE.
  - When the 4th beat is captured, go to CHECK. With zero-wait memory, the first request to CHECK takes 6 cycles.
- CHECK (1 cycle):
  - word3[31]==0 -> DONE; descriptor is not presented.
  - Otherwise load desc_* fields, desc_valid=1, go to PRESENT.
- PRESENT:
  - desc_valid and fields are held stable until desc_ready=1.
  - On the handshake cycle: desc_valid=0 and desc_count increments. Then evaluate in priority order:
    1. stop latched -> DONE.
    2. desc_next==0 -> DONE.
    3. desc_next[1:0]!=0 -> ERROR.
    4. desc_count (post-increment) == MAX_DESC -> ERROR.
    5. Otherwise base<=desc_next[ADDR_W-1:0], go to ISSUE.
- stop:
  - Latched whenever busy=1; never aborts in-flight Avalon reads.
  - stop and the handshake in the same cycle counts as latched.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- ERROR: error=1 for one cycle, busy=0, return to IDLE.
- A start arriving in the same cycle as done/error is ignored.
- desc_count holds its value after the walk ends until the next accepted start.
- Readdatavalid beats arriving with no outstanding read (e.g. after reset) are ignored.

Test Plan:
- Chain of 3 at byte addresses 0x000->0x010->0x020, last next=0, all OWNED, desc_ready=1, zero-wait memory -> three descriptors with correct fields; m_address sequence 0x000,0x004,0x008,0x00C,0x010,...; one done pulse; desc_count=3; busy falls with done.
- First descriptor word3=0x0000_0000 -> no desc_valid; done pulse; desc_count=0.
- m_waitrequest high for 3 cycles on the 2nd request, desc_ready delayed 5 cycles -> m_address/m_read held stable during the wait; desc fields stable while desc_valid=1; exactly 4 reads per descriptor.
- start_addr=0x002 -> error pulse, no m_read. Separately, a descriptor with next=0x013 -> that descriptor is presented, then error pulse.
- Self-loop next=0x040 at 0x040, MAX_DESC=4 -> exactly 4 presentations, then error; desc_count=4.
- stop pulsed during ISSUE of the 2nd descriptor -> 2nd descriptor completes its reads and is presented, then done. Separately, reset asserted mid-WAIT_DATA -> all outputs return to reset values immediately; a fresh start re-walks correctly.
